univ_register: RTL

- Parametrised universal register, the successor to the plain 8-bit load register.
- Adds hold, load, multi-bit shift and rotate (one bit per cycle), and up/down count, driven by a start/busy/done handshake.
- Used as a datapath working register and as a serialiser/deserialiser front end.

---
 rtl/univ_register_if.sv | 55 +++++
 rtl/univ_register.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/univ_register_if.sv
// -----------------------------------------------------------------------------
// univ_register_if
//   Bus bundle for the universal register. The requester (master) drives the
//   operation request and the serial fill bit. The register (slave) returns its
//   contents and status.
//
//   Signals:
//     data   [WIDTH]    load value
//     op     [3]        operation code
//     start  [1]        request
//     shamt  [SHAMT_W]  shift/rotate bit count
//     sin    [1]        serial fill bit for shifts
//     out    [WIDTH]    register contents
//     busy   [1]        multi-cycle shift/rotate in progress
//     done   [1]        one-cycle completion pulse
//     carry  [1]        last bit shifted/rotated out, or count wrap flag
//     zero   [1]        out == 0
//     parity [1]        XOR reduction of out (only with UREG_PARITY_EN)
// -----------------------------------------------------------------------------
interface univ_register_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
);
    logic [WIDTH-1:0]   data;
    logic [2:0]         op;
    logic               start;
    logic [SHAMT_W-1:0] shamt;
    logic               sin;
    logic [WIDTH-1:0]   out;
    logic               busy;
    logic               done;
    logic               carry;
    logic               zero;
`ifdef UREG_PARITY_EN
    logic               parity;

    modport master (
        output data, op, start, shamt, sin,
        input  out, busy, done, carry, zero, parity
    );
    modport slave (
        input  data, op, start, shamt, sin,
        output out, busy, done, carry, zero, parity
    );
`else
    modport master (
        output data, op, start, shamt, sin,
        input  out, busy, done, carry, zero
    );
    modport slave (
        input  data, op, start, shamt, sin,
        output out, busy, done, carry, zero
    );
`endif
endinterface

// File: rtl/univ_register.sv
// -----------------------------------------------------------------------------
// univ_register
//   Parametrised universal register. It supports hold, load, up/down count,
//   and multi-bit shift/rotate, one bit per cycle. Requests use a
//   start/busy/done handshake.
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  univ_register_if.slave (data, op, start, shamt, sin in;
//          out, busy, done, carry, zero [, parity] out)
//
//   Optional feature: define UREG_PARITY_EN to add a registered bus.parity
//   output. It equals ^out and resets to ^RST_VAL.
// -----------------------------------------------------------------------------
module univ_register #(
    parameter int               WIDTH   = 8,
    parameter int               SHAMT_W = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    univ_register_if.slave bus
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_UP   = 3'b110,
        OP_DOWN = 3'b111
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_n;
    op_t                op_r, op_n;
    op_t                req_op;
    logic [WIDTH-1:0]   out_r, out_n;
    logic               carry_r, carry_n;
    logic               done_r, done_n;
    logic [SHAMT_W-1:0] cnt, cnt_n;

    assign req_op = op_t'(bus.op);

    // One shift/rotate step. It returns {bit moved out, new value}.
    function automatic logic [WIDTH:0] step(input op_t o, input logic [WIDTH-1:0] v,
                                            input logic s);
        case (o)
            OP_SHL:  step = {v[WIDTH-1], v[WIDTH-2:0], s};
            OP_SHR:  step = {v[0], s, v[WIDTH-1:1]};
            OP_ROL:  step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  step = {v[0], v[0], v[WIDTH-1:1]};
            default: step = {1'b0, v};
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave a value unassigned and infer a latch.
        state_n = state;
        op_n    = op_r;
        out_n   = out_r;
        carry_n = carry_r;
        cnt_n   = cnt;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    op_n = req_op;
                    case (req_op)
                        OP_HOLD: done_n = 1'b1;
                        OP_LOAD: begin
                            out_n   = bus.data;
                            carry_n = 1'b0;
                            done_n  = 1'b1;
                        end
                        // The extra top bit of a WIDTH+1 add/subtract is set
                        // only on the wrap (all-ones->0 up, 0->all-ones down).
                        OP_UP: begin
                            {carry_n, out_n} = {1'b0, out_r} + (WIDTH+1)'(1);
                            done_n           = 1'b1;
                        end
                        OP_DOWN: begin
                            {carry_n, out_n} = {1'b0, out_r} - (WIDTH+1)'(1);
                            done_n           = 1'b1;
                        end
                        default: begin
                            if (bus.shamt == '0) begin
                                done_n = 1'b1;
                            end else begin
                                // The first bit moves on the accept edge itself.
                                {carry_n, out_n} = step(req_op, out_r, bus.sin);
                                cnt_n            = bus.shamt - 1'b1;
                                if (bus.shamt == SHAMT_W'(1))
                                    done_n = 1'b1;
                                else
                                    state_n = RUN;
                            end
                        end
                    endcase
                end
            end
            RUN: begin
                {carry_n, out_n} = step(op_r, out_r, bus.sin);
                cnt_n            = cnt - 1'b1;
                if (cnt == SHAMT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_r    <= OP_HOLD;
            out_r   <= RST_VAL;
            carry_r <= 1'b0;
            done_r  <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            op_r    <= op_n;
            out_r   <= out_n;
            carry_r <= carry_n;
            done_r  <= done_n;
            cnt     <= cnt_n;
        end
    end

`ifdef UREG_PARITY_EN
    logic parity_r;

    // Tracks out_n every edge, so it changes exactly when out does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_r <= ^RST_VAL;
        else
            parity_r <= ^out_n;
    end

    assign bus.parity = parity_r;
`endif

    assign bus.out   = out_r;
    assign bus.busy  = (state == RUN);
    assign bus.done  = done_r;
    assign bus.carry = carry_r;
    assign bus.zero  = (out_r == '0);

endmodule
